branch_pc_unit: RTL and testbench

//   Program-counter unit for the core: holds the PC and produces the next PC each cycle.

---
 rtl/branch_pc_pkg.sv | 24 ++
 rtl/branch_pc_unit_return_stack.sv | 46 ++++
 rtl/branch_pc_unit.sv | 126 ++++++++++++
 tb/tb_branch_pc_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/branch_pc_pkg.sv
// Shared types and constants for the branch/PC unit: FSM states and the
// power-on contents of the branch target LUT.
package branch_pc_pkg;

  typedef enum logic {
    S_HALT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int unsigned LUT_IDX_NEG5  = 0;
  localparam int unsigned LUT_IDX_POS20 = 1;
  localparam int unsigned LUT_IDX_NEG1  = 2;

  // Two's-complement default values at 64 bits; callers keep the low D bits.
  function automatic logic [63:0] lut_default(input int unsigned idx);
    logic [63:0] val;
    val = '0;
    if (idx == LUT_IDX_NEG5)       val = -64'sd5;
    else if (idx == LUT_IDX_POS20) val = 64'd20;
    else if (idx == LUT_IDX_NEG1)  val = '1;
    return val;
  endfunction

endpackage

// File: rtl/branch_pc_unit_return_stack.sv
// Parametrised LIFO holding return addresses for call/ret.
// The parent never issues push and pop in the same cycle.
module return_stack #(
  parameter int unsigned D        = 12,
  parameter int unsigned RS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned CW = $clog2(RS_DEPTH + 1);

  logic [D-1:0]  mem [RS_DEPTH];
  logic [CW-1:0] count;

  assign full  = (count == CW'(RS_DEPTH));
  assign empty = (count == '0);

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (count == CW'(i + 1)) top = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int unsigned i = 0; i < RS_DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (count == CW'(i)) mem[i] <= push_data;
      end
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Program-counter unit: HALT/RUN control, branch target selection from an
// immediate or a writable LUT, and call/ret through a small return stack.
module branch_pc_unit
  import branch_pc_pkg::*;
#(
  parameter int unsigned D        = 12,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned RS_DEPTH = 4,
  parameter logic [D-1:0] RESET_PC = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_en,
  input  logic             call,
  input  logic             ret,
  input  logic             imm_or_lut,
  input  logic             abs_mode,
  input  logic [SEL_W-1:0] pc_ctrl_input,
  input  logic             lut_we,
  input  logic [SEL_W-1:0] lut_waddr,
  input  logic [D-1:0]     lut_wdata,
  output logic [D-1:0]     prog_ctr,
  output logic             halted,
  output logic             rs_overflow,
  output logic             rs_underflow
);

  localparam int unsigned LUT_DEPTH = 2 ** SEL_W;

  state_t       state, state_n;
  logic [D-1:0] pc_n;
  logic [D-1:0] lut [LUT_DEPTH];
  logic [D-1:0] target, jump_pc, inc_pc, rs_top;
  logic         rs_push, rs_pop, rs_full, rs_empty;
  logic         ovf_n, unf_n;

  return_stack #(
    .D        (D),
    .RS_DEPTH (RS_DEPTH)
  ) u_rs (
    .clk       (Clk),
    .reset     (Reset),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (inc_pc),
    .top       (rs_top),
    .full      (rs_full),
    .empty     (rs_empty)
  );

  // LUT read is combinational on the current array, so a same-cycle write
  // to the same index is only seen on the following cycle.
  assign target  = imm_or_lut ? lut[pc_ctrl_input]
                              : {{(D-SEL_W){pc_ctrl_input[SEL_W-1]}}, pc_ctrl_input};
  assign jump_pc = abs_mode ? target : prog_ctr + target;
  assign inc_pc  = prog_ctr + D'(1);
  assign halted  = (state == S_HALT);

  always_comb begin
    state_n = state;
    pc_n    = prog_ctr;
    rs_push = 1'b0;
    rs_pop  = 1'b0;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
    unique case (state)
      S_HALT: begin
        if (start) state_n = S_RUN;
      end
      S_RUN: begin
        if (stall) begin
          state_n = S_RUN;
        end else if (halt_req) begin
          state_n = S_HALT;
        end else if (ret) begin
          if (!rs_empty) begin
            pc_n   = rs_top;
            rs_pop = 1'b1;
          end else begin
            pc_n  = inc_pc;
            unf_n = 1'b1;
          end
        end else if (call) begin
          pc_n = jump_pc;
          if (!rs_full) rs_push = 1'b1;
          else          ovf_n   = 1'b1;
        end else if (branch_en) begin
          pc_n = jump_pc;
        end else begin
          pc_n = inc_pc;
        end
      end
      default: state_n = S_HALT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_HALT;
      prog_ctr     <= RESET_PC;
      rs_overflow  <= 1'b0;
      rs_underflow <= 1'b0;
    end else begin
      state        <= state_n;
      prog_ctr     <= pc_n;
      rs_overflow  <= ovf_n;
      rs_underflow <= unf_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
        logic [63:0] dflt;
        dflt   = lut_default(i);
        lut[i] <= dflt[D-1:0];
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with hand-computed expected PC values.
module tb_branch_pc_unit;

  logic        Clk = 1'b0;
  logic        Reset, start, stall, halt_req, branch_en, call, ret;
  logic        imm_or_lut, abs_mode, lut_we;
  logic [3:0]  pc_ctrl_input, lut_waddr;
  logic [11:0] lut_wdata;
  logic [11:0] prog_ctr;
  logic        halted, rs_overflow, rs_underflow;

  int checks = 0;
  int errors = 0;

  branch_pc_unit #(
    .D        (12),
    .SEL_W    (4),
    .RS_DEPTH (4),
    .RESET_PC (12'd0)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .start         (start),
    .stall         (stall),
    .halt_req      (halt_req),
    .branch_en     (branch_en),
    .call          (call),
    .ret           (ret),
    .imm_or_lut    (imm_or_lut),
    .abs_mode      (abs_mode),
    .pc_ctrl_input (pc_ctrl_input),
    .lut_we        (lut_we),
    .lut_waddr     (lut_waddr),
    .lut_wdata     (lut_wdata),
    .prog_ctr      (prog_ctr),
    .halted        (halted),
    .rs_overflow   (rs_overflow),
    .rs_underflow  (rs_underflow)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    start = 0; stall = 0; halt_req = 0; branch_en = 0; call = 0; ret = 0;
    imm_or_lut = 0; abs_mode = 0; lut_we = 0;
    pc_ctrl_input = '0; lut_waddr = '0; lut_wdata = '0;
  endtask

  initial begin
    idle();
    Reset = 1;
    step(); step();
    Reset = 0;
    chk("rst_pc", prog_ctr, 0);
    chk("rst_halted", halted, 1);
    chk("rst_ovf", rs_overflow, 0);
    chk("rst_unf", rs_underflow, 0);

    start = 1; step(); start = 0;
    chk("start_halted", halted, 0);
    chk("start_pc", prog_ctr, 0);
    step(); chk("inc1", prog_ctr, 1);
    step(); chk("inc2", prog_ctr, 2);
    step(); chk("inc3", prog_ctr, 3);
    for (int i = 0; i < 7; i++) step();
    chk("inc10", prog_ctr, 10);

    branch_en = 1; pc_ctrl_input = 4'b1110; step();
    chk("rel_imm_neg2", prog_ctr, 8);
    abs_mode = 1; pc_ctrl_input = 4'b0101; step();
    chk("abs_imm5", prog_ctr, 5);
    pc_ctrl_input = 4'b0000; step();
    chk("abs_imm0", prog_ctr, 0);

    abs_mode = 0; imm_or_lut = 1; pc_ctrl_input = 4'd2; step();
    chk("rel_lut_wrap_down", prog_ctr, 4095);

    // Same-cycle write and read of index 3 must still see the default 0.
    abs_mode = 1; pc_ctrl_input = 4'd3;
    lut_we = 1; lut_waddr = 4'd3; lut_wdata = 12'd100; step();
    lut_we = 0;
    chk("lut_read_old", prog_ctr, 0);
    step();
    chk("lut_read_new", prog_ctr, 100);
    abs_mode = 0; pc_ctrl_input = 4'd0; step();
    chk("rel_lut_neg5", prog_ctr, 95);
    abs_mode = 1; pc_ctrl_input = 4'd2; step();
    chk("abs_lut_4095", prog_ctr, 4095);
    idle(); step();
    chk("inc_wrap_up", prog_ctr, 0);

    branch_en = 1; imm_or_lut = 1; abs_mode = 1; pc_ctrl_input = 4'd1; step();
    chk("abs_lut_20", prog_ctr, 20);
    idle(); call = 1; imm_or_lut = 1; pc_ctrl_input = 4'd1; step();
    chk("call_rel_lut", prog_ctr, 40);
    idle(); ret = 1; step();
    chk("ret_pc", prog_ctr, 21);
    chk("ret_unf", rs_underflow, 0);

    idle(); call = 1; abs_mode = 1; pc_ctrl_input = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("call_fill_pc", prog_ctr, 3);
      chk("call_fill_ovf", rs_overflow, 0);
    end
    step();
    chk("call_full_pc", prog_ctr, 3);
    chk("call_full_ovf", rs_overflow, 1);
    idle(); step();
    chk("ovf_one_cycle", rs_overflow, 0);
    chk("after_ovf_pc", prog_ctr, 4);

    ret = 1;
    step(); chk("pop1", prog_ctr, 4);
    step(); chk("pop2", prog_ctr, 4);
    step(); chk("pop3", prog_ctr, 4);
    step(); chk("pop4", prog_ctr, 22);
    chk("pop4_unf", rs_underflow, 0);
    step();
    chk("ret_empty_pc", prog_ctr, 23);
    chk("ret_empty_unf", rs_underflow, 1);
    idle(); step();
    chk("unf_one_cycle", rs_underflow, 0);
    chk("after_unf_pc", prog_ctr, 24);

    branch_en = 1; abs_mode = 1; pc_ctrl_input = 4'b0111; step();
    chk("abs_imm7", prog_ctr, 7);
    stall = 1; pc_ctrl_input = 4'b0011; step();
    chk("stall_pc", prog_ctr, 7);
    idle(); halt_req = 1; step();
    chk("halt_halted", halted, 1);
    chk("halt_pc", prog_ctr, 7);
    idle(); branch_en = 1; abs_mode = 1; pc_ctrl_input = 4'b0011; step();
    chk("halt_ignores_branch", prog_ctr, 7);
    chk("halt_stays", halted, 1);

    idle(); start = 1; step();
    idle(); lut_we = 1; lut_waddr = 4'd0; lut_wdata = 12'd50; step();
    chk("run_after_restart", prog_ctr, 8);
    idle(); call = 1; abs_mode = 1; pc_ctrl_input = 4'b0011; step();
    chk("call_before_reset", prog_ctr, 3);
    lut_we = 1; lut_waddr = 4'd1; lut_wdata = 12'd77; Reset = 1; step();
    Reset = 0; idle();
    chk("mid_rst_pc", prog_ctr, 0);
    chk("mid_rst_halted", halted, 1);
    start = 1; step(); idle();
    ret = 1; step();
    chk("mid_rst_stack_empty_pc", prog_ctr, 1);
    chk("mid_rst_stack_empty_unf", rs_underflow, 1);
    idle(); branch_en = 1; imm_or_lut = 1; pc_ctrl_input = 4'd0; step();
    chk("mid_rst_lut0_default", prog_ctr, 4092);
    abs_mode = 1; pc_ctrl_input = 4'd1; step();
    chk("mid_rst_lut1_default", prog_ctr, 20);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
